// File: rtl/stream_sorter_n.sv
// ----------------------------------------------------------------------------
// stream_sorter_n
//   Block sorter. Collects pNUM words from the input AXI-Stream, sorts them
//   with an odd-even transposition network (one pass per cycle, pNUM passes),
//   then streams the sorted block out with full backpressure support.
//   Sort direction and signedness are configured over AXI-Lite.
//
// Ports
//   axis_clk, axis_rst_n     : clock, asynchronous active-low reset
//   aw*/w*                   : AXI-Lite write (address + data, same cycle)
//   ar*/r*                   : AXI-Lite read (rdata registered)
//   ss_tvalid/tready/tdata/tlast : input stream
//   sm_tvalid/tready/tdata/tlast : output stream
//
// Register map
//   0x00 ap_ctrl : [0] ap_start W1S, [1] ap_done RO/COR, [2] ap_idle RO,
//                  [3] tlast_err RO sticky
//   0x10 cfg     : [0] desc, [1] sgn (writable only while idle)
//   0x18 perf    : cycle counter, present only when SORTER_PERF_CNT_EN is
//                  defined; reads 0 otherwise.
// ----------------------------------------------------------------------------
module stream_sorter_n #(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int pNUM        = 10
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   input  logic                   awvalid,
   output logic                   awready,
   input  logic [pADDR_WIDTH-1:0] awaddr,
   input  logic                   wvalid,
   output logic                   wready,
   input  logic [pDATA_WIDTH-1:0] wdata,
   input  logic                   arvalid,
   output logic                   arready,
   input  logic [pADDR_WIDTH-1:0] araddr,
   output logic                   rvalid,
   input  logic                   rready,
   output logic [pDATA_WIDTH-1:0] rdata,
   input  logic                   ss_tvalid,
   output logic                   ss_tready,
   input  logic [pDATA_WIDTH-1:0] ss_tdata,
   input  logic                   ss_tlast,
   output logic                   sm_tvalid,
   input  logic                   sm_tready,
   output logic [pDATA_WIDTH-1:0] sm_tdata,
   output logic                   sm_tlast
);

   localparam int CW = $clog2(pNUM);
   localparam logic [CW-1:0] LAST_IDX = CW'(pNUM - 1);
   localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'(12'h000);
   localparam logic [pADDR_WIDTH-1:0] ADDR_CFG  = pADDR_WIDTH'(12'h010);
`ifdef SORTER_PERF_CNT_EN
   localparam logic [pADDR_WIDTH-1:0] ADDR_PERF = pADDR_WIDTH'(12'h018);
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_SORT = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   // Magnitude compare in either signed or unsigned interpretation.
   function automatic logic is_greater(input logic [pDATA_WIDTH-1:0] a,
                                       input logic [pDATA_WIDTH-1:0] b,
                                       input logic                   sgn);
      logic res;
      if (sgn) begin
         res = ($signed(a) > $signed(b));
      end else begin
         res = (a > b);
      end
      return res;
   endfunction

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [pDATA_WIDTH-1:0]  elem_q [pNUM];
   logic [pDATA_WIDTH-1:0]  elem_d [pNUM];
   logic [pDATA_WIDTH-1:0]  sorted_s [pNUM];
   logic [pNUM-2:0]         swap_s;

   logic desc_q, desc_d, sgn_q, sgn_d;
   logic run_desc_q, run_desc_d, run_sgn_q, run_sgn_d;
   logic ap_done_q, ap_done_d, tlast_err_q, tlast_err_d;
   logic rvalid_q, rvalid_d;
   logic [pDATA_WIDTH-1:0] rdata_q, rdata_d, rd_val_s;
   logic ss_tready_q, ss_tready_d, sm_tvalid_q, sm_tvalid_d, sm_tlast_q, sm_tlast_d;
   logic [pDATA_WIDTH-1:0] sm_tdata_q, sm_tdata_d;
`ifdef SORTER_PERF_CNT_EN
   logic [31:0] perf_q, perf_d;
`endif

   logic wr_hs_s, ar_hs_s, start_s, in_hs_s, out_hs_s, done_set_s;
   logic unused_s;

   // The write channel completes only when address and data arrive together.
   assign awready  = awvalid & wvalid;
   assign wready   = awvalid & wvalid;
   assign arready  = ~rvalid_q;
   assign rvalid   = rvalid_q;
   assign rdata    = rdata_q;
   assign ss_tready = ss_tready_q;
   assign sm_tvalid = sm_tvalid_q;
   assign sm_tdata  = sm_tdata_q;
   assign sm_tlast  = sm_tlast_q;

   assign wr_hs_s    = awvalid & wvalid;
   assign ar_hs_s    = arvalid & ~rvalid_q;
   assign start_s    = wr_hs_s & (awaddr == ADDR_CTRL) & wdata[0] & (state_q == S_IDLE);
   assign in_hs_s    = ss_tvalid & ss_tready_q;
   assign out_hs_s   = sm_tvalid_q & sm_tready;
   assign done_set_s = (state_q == S_OUT) & out_hs_s & (cnt_q == LAST_IDX);
   assign unused_s   = ^{wdata[pDATA_WIDTH-1:2]};

   // One transposition pass: pair parity follows the pass number.
   always_comb begin
      swap_s = '0;
      for (int i = 0; i < pNUM - 1; i++) begin
         swap_s[i] = ((i % 2) == int'(cnt_q[0])) &&
                     (run_desc_q ? is_greater(elem_q[i+1], elem_q[i], run_sgn_q)
                                 : is_greater(elem_q[i], elem_q[i+1], run_sgn_q));
      end
   end

   // Apply the swap decisions; pairs never overlap within a pass.
   always_comb begin
      sorted_s[0] = swap_s[0] ? elem_q[1] : elem_q[0];
      for (int k = 1; k < pNUM - 1; k++) begin
         sorted_s[k] = swap_s[k]   ? elem_q[k+1] :
                       swap_s[k-1] ? elem_q[k-1] : elem_q[k];
      end
      sorted_s[pNUM-1] = swap_s[pNUM-2] ? elem_q[pNUM-2] : elem_q[pNUM-1];
   end

   // Next-state logic for the IDLE/LOAD/SORT/OUT sequencer and element store.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      elem_d  = elem_q;
      case (state_q)
         S_IDLE: begin
            if (start_s) begin
               state_d = S_LOAD;
               cnt_d   = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            if (in_hs_s) begin
               elem_d[cnt_q] = ss_tdata;
               if (cnt_q == LAST_IDX) begin
                  state_d = S_SORT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         S_SORT: begin
            elem_d = sorted_s;
            if (cnt_q == LAST_IDX) begin
               state_d = S_OUT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_OUT: begin
            if (out_hs_s) begin
               if (cnt_q == LAST_IDX) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Stream outputs are registered from the next state so they hold while stalled.
   always_comb begin
      ss_tready_d = (state_d == S_LOAD);
      sm_tvalid_d = (state_d == S_OUT);
      sm_tlast_d  = (state_d == S_OUT) && (cnt_d == LAST_IDX);
      if (state_d == S_OUT) begin
         sm_tdata_d = elem_d[cnt_d];
      end else begin
         sm_tdata_d = '0;
      end
   end

   // Register file, status bits and AXI-Lite read path.
   always_comb begin
      desc_d      = desc_q;
      sgn_d       = sgn_q;
      run_desc_d  = run_desc_q;
      run_sgn_d   = run_sgn_q;
      tlast_err_d = tlast_err_q;
      ap_done_d   = ap_done_q;
      rvalid_d    = rvalid_q;
      rdata_d     = rdata_q;
      rd_val_s    = '0;

      if (wr_hs_s && (awaddr == ADDR_CFG) && (state_q == S_IDLE)) begin
         desc_d = wdata[0];
         sgn_d  = wdata[1];
      end else begin
         desc_d = desc_q;
      end

      // Error flag: tlast must appear exactly on the final beat.
      if (start_s) begin
         run_desc_d  = desc_q;
         run_sgn_d   = sgn_q;
         tlast_err_d = 1'b0;
      end else if (in_hs_s && (ss_tlast != (cnt_q == LAST_IDX))) begin
         tlast_err_d = 1'b1;
      end else begin
         tlast_err_d = tlast_err_q;
      end

      case (araddr)
         ADDR_CTRL: begin
            rd_val_s[1] = ap_done_q | done_set_s;
            rd_val_s[2] = (state_q == S_IDLE);
            rd_val_s[3] = tlast_err_q;
         end
         ADDR_CFG: begin
            rd_val_s[0] = desc_q;
            rd_val_s[1] = sgn_q;
         end
`ifdef SORTER_PERF_CNT_EN
         ADDR_PERF: begin
            rd_val_s = pDATA_WIDTH'(perf_q);
         end
`endif
         default: begin
            rd_val_s = '0;
         end
      endcase

      // A read that coincides with done being set must not lose the event.
      if (done_set_s) begin
         ap_done_d = 1'b1;
      end else if (ar_hs_s && (araddr == ADDR_CTRL)) begin
         ap_done_d = 1'b0;
      end else begin
         ap_done_d = ap_done_q;
      end

      if (ar_hs_s) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_val_s;
      end else if (rvalid_q && rready) begin
         rvalid_d = 1'b0;
      end else begin
         rvalid_d = rvalid_q;
      end
   end

`ifdef SORTER_PERF_CNT_EN
   // Saturating run-length counter, restarted by each accepted ap_start.
   always_comb begin
      if (start_s) begin
         perf_d = 32'd0;
      end else if ((state_q != S_IDLE) && (perf_q != 32'hFFFF_FFFF)) begin
         perf_d = perf_q + 32'd1;
      end else begin
         perf_d = perf_q;
      end
   end

   // Performance counter register.
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         perf_q <= 32'd0;
      end else begin
         perf_q <= perf_d;
      end
   end
`endif

   // Sequencer state, counters, element store and stream output registers.
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         for (int i = 0; i < pNUM; i++) begin
            elem_q[i] <= '0;
         end
         ss_tready_q <= 1'b0;
         sm_tvalid_q <= 1'b0;
         sm_tlast_q  <= 1'b0;
         sm_tdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         elem_q      <= elem_d;
         ss_tready_q <= ss_tready_d;
         sm_tvalid_q <= sm_tvalid_d;
         sm_tlast_q  <= sm_tlast_d;
         sm_tdata_q  <= sm_tdata_d;
      end
   end

   // Control/status and AXI-Lite read registers.
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         desc_q      <= 1'b0;
         sgn_q       <= 1'b0;
         run_desc_q  <= 1'b0;
         run_sgn_q   <= 1'b0;
         tlast_err_q <= 1'b0;
         ap_done_q   <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
      end else begin
         desc_q      <= desc_d;
         sgn_q       <= sgn_d;
         run_desc_q  <= run_desc_d;
         run_sgn_q   <= run_sgn_d;
         tlast_err_q <= tlast_err_d;
         ap_done_q   <= ap_done_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
      end
   end

endmodule

// File: tb/tb_stream_sorter_n.sv
// ----------------------------------------------------------------------------
// tb_stream_sorter_n
//   Directed bench for stream_sorter_n (pNUM = 10, 32-bit data). Each block
//   is loaded, sorted and drained; every output beat is compared against a
//   hand-sorted table. Define SORTER_PERF_CNT_EN to also check register 0x18.
// ----------------------------------------------------------------------------
module tb_stream_sorter_n;

   localparam int NUM = 10;

   logic        clk, rst_n;
   logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
   logic [11:0] awaddr, araddr;
   logic [31:0] wdata, rdata;
   logic        ss_tvalid, ss_tready, ss_tlast;
   logic [31:0] ss_tdata;
   logic        sm_tvalid, sm_tready, sm_tlast;
   logic [31:0] sm_tdata;

   logic [31:0] din  [NUM];
   logic [31:0] dexp [NUM];
   logic [31:0] rd, done_rd;
   int          n_checks, n_fails, cyc, t_start, t_end;

   stream_sorter_n dut (
      .axis_clk(clk), .axis_rst_n(rst_n),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .rvalid(rvalid), .rready(rready), .rdata(rdata),
      .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
      .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running cycle count used to measure the run length.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic axil_write(input logic [11:0] addr, input logic [31:0] data);
      @(negedge clk);
      awvalid = 1'b1; wvalid = 1'b1; awaddr = addr; wdata = data;
      @(posedge clk); #1;
      t_start = cyc;
      awvalid = 1'b0; wvalid = 1'b0;
   endtask

   task automatic axil_read(input logic [11:0] addr, output logic [31:0] data);
      int n;
      @(negedge clk);
      arvalid = 1'b1; araddr = addr;
      n = 0;
      while (!arready && n < 10) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
      arvalid = 1'b0;
      @(negedge clk);
      check_eq("rvalid", rvalid, 1);
      data = rdata;
   endtask

   task automatic send(input int last_idx);
      int n;
      for (int k = 0; k < NUM; k++) begin
         @(negedge clk);
         ss_tvalid = 1'b1; ss_tdata = din[k]; ss_tlast = (k == last_idx);
         n = 0;
         while (!ss_tready && n < 20) begin
            @(negedge clk);
            n++;
         end
         @(posedge clk);
      end
   endtask

   // Drain one block; mode 1 gives sm_tready one cycle on, three cycles off.
   task automatic collect(input int mode, input bit rd_at_done);
      int   lat, idx, ph, guard;
      logic rdy;
      lat = 0;
      do begin
         @(negedge clk);
         ss_tvalid = 1'b0; ss_tlast = 1'b0;
         lat++;
      end while (!sm_tvalid && lat < 100);
      check_eq("latency", lat, NUM + 1);
      idx = 0; ph = 0; guard = 0;
      while (idx < NUM && guard < 200) begin
         rdy = (mode == 0) ? 1'b1 : ((ph % 4) == 0);
         ph++; guard++;
         sm_tready = rdy;
         check_eq("out_valid", sm_tvalid, 1);
         check_eq("out_data", sm_tdata, dexp[idx]);
         check_eq("out_last", sm_tlast, (idx == NUM - 1));
         if (rd_at_done && rdy && idx == NUM - 1) begin
            arvalid = 1'b1; araddr = 12'h000;
         end
         @(posedge clk); #1;
         arvalid = 1'b0;
         if (rdy) begin
            if (idx == NUM - 1) t_end = cyc;
            idx++;
         end
         @(negedge clk);
      end
      check_eq("out_count", idx, NUM);
      if (rd_at_done) begin
         check_eq("rvalid_at_done", rvalid, 1);
         done_rd = rdata;
      end
      sm_tready = 1'b0;
      check_eq("out_valid_after", sm_tvalid, 0);
   endtask

   initial begin
      logic [31:0] exp_perf;
      n_checks = 0; n_fails = 0; cyc = 0; t_start = 0; t_end = 0;
      awvalid = 1'b0; wvalid = 1'b0; awaddr = 12'h000; wdata = 32'h0;
      arvalid = 1'b0; araddr = 12'h000; rready = 1'b1;
      ss_tvalid = 1'b0; ss_tdata = 32'h0; ss_tlast = 1'b0; sm_tready = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset state
      check_eq("rst_ss_tready", ss_tready, 0);
      check_eq("rst_sm_tvalid", sm_tvalid, 0);
      check_eq("rst_sm_tdata", sm_tdata, 32'h0);
      check_eq("rst_sm_tlast", sm_tlast, 0);
      check_eq("rst_arready", arready, 1);
      check_eq("rst_awready", awready, 0);
      check_eq("rst_rdata", rdata, 32'h0);
      axil_read(12'h000, rd); check_eq("rst_ctrl", rd, 32'h4);

      // T1: ascending unsigned, no backpressure
      din  = '{32'd9, 32'd3, 32'd7, 32'd1, 32'd8, 32'd2, 32'd6, 32'd0, 32'd5, 32'd4};
      dexp = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
      axil_write(12'h000, 32'h1);
      send(NUM - 1);
      collect(0, 1'b0);
      axil_read(12'h000, rd); check_eq("t1_ctrl_done", rd, 32'h6);
      axil_read(12'h000, rd); check_eq("t1_ctrl_cleared", rd, 32'h4);
`ifdef SORTER_PERF_CNT_EN
      exp_perf = 32'(t_end - t_start);
`else
      exp_perf = 32'h0;
`endif
      axil_read(12'h018, rd); check_eq("perf_cnt", rd, exp_perf);
      axil_read(12'h004, rd); check_eq("unmapped_rd", rd, 32'h0);

      // T2: descending signed; ctrl read lands on the cycle ap_done sets
      axil_write(12'h010, 32'h3);
      axil_read(12'h010, rd); check_eq("t2_cfg", rd, 32'h3);
      din  = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFF9, 32'd3, 32'd0,
               32'd2, 32'hFFFF_FFFE, 32'd9, 32'd1, 32'hFFFF_FFFB};
      dexp = '{32'd9, 32'd5, 32'd3, 32'd2, 32'd1, 32'd0,
               32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFB, 32'hFFFF_FFF9};
      axil_write(12'h000, 32'h1);
      send(NUM - 1);
      collect(0, 1'b1);
      check_eq("t2_done_same_cycle", done_rd, 32'h2);
      axil_read(12'h000, rd); check_eq("t2_done_kept", rd, 32'h6);
      axil_read(12'h000, rd); check_eq("t2_done_cleared", rd, 32'h4);

      // T3: unsigned extremes with output stalls
      axil_write(12'h010, 32'h0);
      din  = '{32'hFFFF_FFFF, 32'd1, 32'h8000_0000, 32'd5, 32'd0,
               32'h7FFF_FFFF, 32'd3, 32'd2, 32'hFFFF_FFFE, 32'd4};
      dexp = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5,
               32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
      axil_write(12'h000, 32'h1);
      send(NUM - 1);
      collect(1, 1'b0);
      axil_read(12'h000, rd); check_eq("t3_ctrl", rd, 32'h6);

      // T4: early tlast; start and cfg writes while busy are ignored
      din  = '{32'd20, 32'd15, 32'd3, 32'd30, 32'd7, 32'd11, 32'd25, 32'd1, 32'd8, 32'd12};
      dexp = '{32'd1, 32'd3, 32'd7, 32'd8, 32'd11, 32'd12, 32'd15, 32'd20, 32'd25, 32'd30};
      axil_write(12'h000, 32'h1);
      axil_write(12'h000, 32'h1);
      axil_write(12'h010, 32'h1);
      axil_read(12'h010, rd); check_eq("t4_cfg_locked", rd, 32'h0);
      axil_read(12'h000, rd); check_eq("t4_ctrl_busy", rd, 32'h0);
      send(3);
      collect(0, 1'b0);
      axil_read(12'h000, rd); check_eq("t4_tlast_err", rd, 32'hE);

      // T5: next start clears tlast_err; reset pulsed during SORT
      axil_write(12'h010, 32'h3);
      axil_write(12'h000, 32'h1);
      axil_read(12'h000, rd); check_eq("t5_err_cleared", rd, 32'h0);
      send(NUM - 1);
      @(negedge clk);
      ss_tvalid = 1'b0; ss_tlast = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_eq("t5_rst_sm_tvalid", sm_tvalid, 0);
      check_eq("t5_rst_ss_tready", ss_tready, 0);
      rst_n = 1'b1;
      @(negedge clk);
      axil_read(12'h000, rd); check_eq("t5_ctrl_idle", rd, 32'h4);
      axil_read(12'h010, rd); check_eq("t5_cfg_reset", rd, 32'h0);

      // T6: full run after reset, with duplicate values
      din  = '{32'd100, 32'd50, 32'd50, 32'd7, 32'd0, 32'd99, 32'd7, 32'd1000, 32'd2, 32'd3};
      dexp = '{32'd0, 32'd2, 32'd3, 32'd7, 32'd7, 32'd50, 32'd50, 32'd99, 32'd100, 32'd1000};
      axil_write(12'h000, 32'h1);
      send(NUM - 1);
      collect(0, 1'b0);
      axil_read(12'h000, rd); check_eq("t6_ctrl", rd, 32'h6);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule
